// File: rtl/keyb_debounce_repeat_if.sv
// Keypad front-end bus: raw key levels in, debounced state, pulses and encoded key out.
// The slave modport is the debounce block; the master modport is the keypad/consumer side.
interface keyb_debounce_repeat_if #(
    parameter int unsigned N_KEYS = 16
);
    localparam int unsigned CODE_W = $clog2(N_KEYS);

    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_held;
    logic [N_KEYS-1:0] key_pulse;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_multi;

    modport master (
        output key_raw,
        input  key_held,
        input  key_pulse,
        input  key_valid,
        input  key_code,
        input  key_multi
    );

    modport slave (
        input  key_raw,
        output key_held,
        output key_pulse,
        output key_valid,
        output key_code,
        output key_multi
    );
endinterface

// File: rtl/keyb_debounce_repeat.sv
// Multi-channel keypad front end: 2-FF sync, debounce FSM, press pulse, priority encoder.
// Optional typematic auto-repeat is built when KEYB_AUTOREPEAT_EN is defined.
module keyb_debounce_repeat #(
    parameter int unsigned N_KEYS        = 16,
    parameter int unsigned DEB_CYCLES    = 4
`ifdef KEYB_AUTOREPEAT_EN
    ,
    parameter int unsigned HOLD_CYCLES   = 50,
    parameter int unsigned REPEAT_CYCLES = 10
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    keyb_debounce_repeat_if.slave kb
);
    localparam int unsigned CODE_W = $clog2(N_KEYS);
    localparam int unsigned DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
`ifdef KEYB_AUTOREPEAT_EN
    localparam int unsigned RMAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } state_t;

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;

    state_t            state_q [N_KEYS];
    state_t            state_d [N_KEYS];
    logic [DCNT_W-1:0] dcnt_q  [N_KEYS];
    logic [DCNT_W-1:0] dcnt_d  [N_KEYS];
`ifdef KEYB_AUTOREPEAT_EN
    logic [RCNT_W-1:0] rcnt_q  [N_KEYS];
    logic [RCNT_W-1:0] rcnt_d  [N_KEYS];
    logic [N_KEYS-1:0] rep_q;
    logic [N_KEYS-1:0] rep_d;
`endif

    logic [N_KEYS-1:0] pulse_q;
    logic [N_KEYS-1:0] pulse_d;
    logic [N_KEYS-1:0] held_q;
    logic [N_KEYS-1:0] held_d;

    logic [CODE_W-1:0] code_c;
    logic              multi_c;

    // Two-stage synchroniser for the asynchronous key pins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= kb.key_raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel state and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(N_KEYS); i++) begin
                state_q[i] <= IDLE;
                dcnt_q[i]  <= '0;
`ifdef KEYB_AUTOREPEAT_EN
                rcnt_q[i]  <= '0;
`endif
            end
`ifdef KEYB_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
            pulse_q <= '0;
            held_q  <= '0;
        end else begin
            for (int i = 0; i < int'(N_KEYS); i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
`ifdef KEYB_AUTOREPEAT_EN
                rcnt_q[i]  <= rcnt_d[i];
`endif
            end
`ifdef KEYB_AUTOREPEAT_EN
            rep_q   <= rep_d;
`endif
            pulse_q <= pulse_d;
            held_q  <= held_d;
        end
    end

    // Debounce / repeat next-state logic, one FSM per channel
    always_comb begin
        for (int i = 0; i < int'(N_KEYS); i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            pulse_d[i] = 1'b0;
`ifdef KEYB_AUTOREPEAT_EN
            rcnt_d[i]  = rcnt_q[i];
            rep_d[i]   = rep_q[i];
`endif
            case (state_q[i])
                IDLE: begin
`ifdef KEYB_AUTOREPEAT_EN
                    rcnt_d[i] = '0;
                    rep_d[i]  = 1'b0;
`endif
                    if (sync2_q[i]) begin
                        state_d[i] = DB_PRESS;
                        dcnt_d[i]  = DCNT_W'(1);
                    end
                end
                DB_PRESS: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = IDLE;
                        dcnt_d[i]  = '0;
                    end else if (dcnt_q[i] >= DCNT_W'(DEB_CYCLES - 1)) begin
                        state_d[i] = HELD;
                        dcnt_d[i]  = '0;
                        pulse_d[i] = 1'b1;
`ifdef KEYB_AUTOREPEAT_EN
                        rcnt_d[i]  = '0;
                        rep_d[i]   = 1'b0;
`endif
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
                    end
                end
                HELD: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = DB_REL;
                        dcnt_d[i]  = DCNT_W'(1);
                    end
`ifdef KEYB_AUTOREPEAT_EN
                    // First interval is HOLD_CYCLES, later ones REPEAT_CYCLES
                    else if (rcnt_q[i] >= (rep_q[i] ? RCNT_W'(REPEAT_CYCLES - 1)
                                                    : RCNT_W'(HOLD_CYCLES - 1))) begin
                        pulse_d[i] = 1'b1;
                        rcnt_d[i]  = '0;
                        rep_d[i]   = 1'b1;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
                    end
`endif
                end
                DB_REL: begin
                    if (sync2_q[i]) begin
                        state_d[i] = HELD;
                        dcnt_d[i]  = '0;
                    end else if (dcnt_q[i] >= DCNT_W'(DEB_CYCLES - 1)) begin
                        state_d[i] = IDLE;
                        dcnt_d[i]  = '0;
`ifdef KEYB_AUTOREPEAT_EN
                        rcnt_d[i]  = '0;
                        rep_d[i]   = 1'b0;
`endif
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
                    end
                end
                default: state_d[i] = IDLE;
            endcase
            held_d[i] = (state_d[i] == HELD) || (state_d[i] == DB_REL);
        end
    end

    // Lowest-index priority encoder and multi-press detect
    always_comb begin
        logic found;
        found   = 1'b0;
        code_c  = '0;
        multi_c = 1'b0;
        for (int i = 0; i < int'(N_KEYS); i++) begin
            if (pulse_q[i]) begin
                if (found) begin
                    multi_c = 1'b1;
                end else begin
                    code_c = CODE_W'(i);
                    found  = 1'b1;
                end
            end
        end
    end

    // Output register stage; encoder lines up with key_pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kb.key_held  <= '0;
            kb.key_pulse <= '0;
            kb.key_valid <= 1'b0;
            kb.key_code  <= '0;
            kb.key_multi <= 1'b0;
        end else begin
            kb.key_held  <= held_q;
            kb.key_pulse <= pulse_q;
            kb.key_valid <= |pulse_q;
            kb.key_code  <= code_c;
            kb.key_multi <= multi_c;
        end
    end

endmodule

// File: tb/tb_keyb_debounce_repeat.sv
// Directed self-checking bench for keyb_debounce_repeat (DEB_CYCLES=4, N_KEYS=16).
// Define KEYB_AUTOREPEAT_EN for both RTL and bench to check the repeat schedule.
module tb_keyb_debounce_repeat;
    localparam int unsigned N_KEYS = 16;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    keyb_debounce_repeat_if #(.N_KEYS(N_KEYS)) kb_if ();

    keyb_debounce_repeat #(
        .N_KEYS     (N_KEYS),
        .DEB_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kb    (kb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs changed before edge E0: quiet through E0+5, pulse after E0+6, then quiet again.
    task automatic expect_pulse(input string tag, input logic [31:0] mask,
                                input logic [31:0] code, input logic [31:0] multi);
        for (int k = 0; k < 6; k++) begin
            tick();
            check({tag, "_early"}, 32'(kb_if.key_pulse), 32'd0);
        end
        tick();
        check({tag, "_pulse"}, 32'(kb_if.key_pulse), mask);
        check({tag, "_valid"}, 32'(kb_if.key_valid), 32'd1);
        check({tag, "_code"},  32'(kb_if.key_code),  code);
        check({tag, "_multi"}, 32'(kb_if.key_multi), multi);
        check({tag, "_held"},  32'(kb_if.key_held) & mask, mask);
        tick();
        check({tag, "_one"},   32'(kb_if.key_pulse), 32'd0);
        check({tag, "_vlow"},  32'(kb_if.key_valid), 32'd0);
        check({tag, "_clow"},  32'(kb_if.key_code),  32'd0);
    endtask

    initial begin
        logic [31:0] exp_p;
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        kb_if.key_raw = '0;

        // Reset state
        tick();
        tick();
        check("rst_held",  32'(kb_if.key_held),  32'd0);
        check("rst_pulse", 32'(kb_if.key_pulse), 32'd0);
        check("rst_valid", 32'(kb_if.key_valid), 32'd0);
        check("rst_code",  32'(kb_if.key_code),  32'd0);
        check("rst_multi", 32'(kb_if.key_multi), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) tick();

        // Single press on key 3, held 20 cycles: one pulse only
        kb_if.key_raw[3] = 1'b1;
        expect_pulse("k3", 32'h8, 32'd3, 32'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("k3_nopulse", 32'(kb_if.key_pulse), 32'd0);
        end
        check("k3_held", 32'(kb_if.key_held), 32'h8);

        // Release latency equals press latency
        kb_if.key_raw[3] = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("k3_rel_still", 32'(kb_if.key_held), 32'h8);
        tick();
        check("k3_rel_done",  32'(kb_if.key_held), 32'h0);
        check("k3_rel_nopul", 32'(kb_if.key_pulse), 32'h0);
        for (int k = 0; k < 3; k++) tick();

        // Key 5 high for only 3 cycles: rejected as a glitch
        kb_if.key_raw[5] = 1'b1;
        tick(); tick(); tick();
        kb_if.key_raw[5] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("k5_pulse", 32'(kb_if.key_pulse), 32'd0);
            check("k5_held",  32'(kb_if.key_held),  32'd0);
            tick();
        end

        // Key 7 with a 2-cycle bounce while held: single pulse, held never drops
        kb_if.key_raw[7] = 1'b1;
        expect_pulse("k7", 32'h80, 32'd7, 32'd0);
        tick(); tick(); tick();
        kb_if.key_raw[7] = 1'b0;
        tick(); tick();
        kb_if.key_raw[7] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            check("k7_bounce_pulse", 32'(kb_if.key_pulse), 32'd0);
            check("k7_bounce_held",  32'(kb_if.key_held),  32'h80);
        end
        kb_if.key_raw[7] = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("k7_released", 32'(kb_if.key_held), 32'd0);

        // Keys 2 and 9 together: both bits, lowest code, multi flag
        kb_if.key_raw[2] = 1'b1;
        kb_if.key_raw[9] = 1'b1;
        expect_pulse("k2k9", 32'h204, 32'd2, 32'd1);
        check("k2k9_multi_low", 32'(kb_if.key_multi), 32'd0);
        kb_if.key_raw[2] = 1'b0;
        kb_if.key_raw[9] = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("k2k9_released", 32'(kb_if.key_held), 32'd0);

        // Key 1 held ~100 cycles: repeat schedule only in the auto-repeat build
        kb_if.key_raw[1] = 1'b1;
        expect_pulse("k1", 32'h2, 32'd1, 32'd0);
        // Loop index i is the number of edges after the first pulse P
        for (int i = 2; i <= 120; i++) begin
            if (i == 94) kb_if.key_raw[1] = 1'b0;
            tick();
`ifdef KEYB_AUTOREPEAT_EN
            exp_p = (i >= 50 && i <= 90 && (i % 10) == 0) ? 32'h2 : 32'h0;
`else
            exp_p = 32'h0;
`endif
            check($sformatf("k1_rep_%0d", i), 32'(kb_if.key_pulse), exp_p);
            if (exp_p != 32'h0) begin
                check("k1_rep_valid", 32'(kb_if.key_valid), 32'd1);
                check("k1_rep_code",  32'(kb_if.key_code),  32'd1);
            end
        end
        check("k1_released", 32'(kb_if.key_held), 32'd0);

        // Reset during HELD with key still pressed: new press after release
        kb_if.key_raw[4] = 1'b1;
        expect_pulse("k4", 32'h10, 32'd4, 32'd0);
        tick(); tick();
        reset = 1'b0;
        #1;
        check("mid_rst_held",  32'(kb_if.key_held),  32'd0);
        check("mid_rst_pulse", 32'(kb_if.key_pulse), 32'd0);
        check("mid_rst_valid", 32'(kb_if.key_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("in_rst_held", 32'(kb_if.key_held), 32'd0);
        end
        reset = 1'b1;
        expect_pulse("k4_after_rst", 32'h10, 32'd4, 32'd0);
        kb_if.key_raw[4] = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("k4_released", 32'(kb_if.key_held), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/keyb_debounce_repeat.md
Name: keyb_debounce_repeat

Overview:
- Multi-channel keypad front end: per-key synchroniser, debounce filter, single-cycle press pulse, optional typematic auto-repeat.
- Encodes pulses into a key code with a valid strobe.
- Sits between the raw keypad pins and the calculator input decoder.
- Supersedes the single-channel anti-repeat filter: N channels, a programmable debounce, and an encoded output.

Parameters:
- N_KEYS, 16, number of key channels (2..32).
- DEB_CYCLES, 4, consecutive stable synchronised samples required to accept a press or release (>=1).
- HOLD_CYCLES, 50, cycles from the initial press pulse to the first repeat pulse (>=1; auto-repeat build only).
- REPEAT_CYCLES, 10, cycles between subsequent repeat pulses (>=1; auto-repeat build only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- key_raw  in  N_KEYS  raw key levels, asynchronous, 1 = pressed.
- key_held  out  N_KEYS  debounced key state per channel.
- key_pulse  out  N_KEYS  one-cycle pulse per accepted press or repeat event.
- key_valid  out  1  high for one cycle when any key_pulse bit is high.
- key_code  out  $clog2(N_KEYS)  index of the lowest set key_pulse bit; 0 when key_valid=0.
- key_multi  out  1  high with key_valid when more than one key_pulse bit is set.

Behaviour:
- Reset (reset=0, async): all outputs 0, sync flops 0, all channels IDLE, all counters 0.
- All outputs are registered; none is combinational from key_raw.
- Synchroniser: 2-FF per channel. sync = second stage.
- Per-channel FSM, with debounce counter dcnt and repeat counter rcnt:
  - IDLE: sync=1 -> DB_PRESS, dcnt=1. Otherwise stay.
  - DB_PRESS: sync=1 and dcnt==DEB_CYCLES-1 -> HELD, key_held=1, key_pulse=1 for one cycle, rcnt=0. sync=1 otherwise -> dcnt++. sync=0 -> IDLE, dcnt=0 (glitch rejected, no pulse).
  - HELD: sync=0 -> DB_REL, dcnt=1. Otherwise auto-repeat handling (Optional Feature).
  - DB_REL: sync=0 and dcnt==DEB_CYCLES-1 -> IDLE, key_held=0, no pulse. sync=1 -> HELD (no new pulse; anti-repeat), rcnt not reset.
  - DEB_CYCLES=1: the DB states are transient for one cycle only; the same rules apply.
- Latency: key_raw rises and is stable before edge E0 -> key_pulse high for exactly one cycle after edge E0+DEB_CYCLES+2. Release latency to key_held=0 is identical.
- Encoder (same cycle as key_pulse):
  - key_valid = OR of key_pulse.
  - key_code = lowest set index.
  - key_multi = popcount>1.
- Simultaneous pulses: all key_pulse bits are visible; key_code gives priority to the lowest index.
- Key held through reset deassertion: treated as a new press; pulse after DEB_CYCLES+2 edges.
- Reset mid-operation: immediate return to reset values; any pending pulse is lost.

Optional Feature:
- Macro: KEYB_AUTOREPEAT_EN.
- Defined:
  - In HELD, rcnt counts every cycle.
  - First repeat pulse when rcnt reaches HOLD_CYCLES after the initial pulse; rcnt is then reloaded.
  - Further repeat pulses every REPEAT_CYCLES while the key stays HELD.
  - DB_REL freezes rcnt; returning to HELD resumes the count.
  - Entering IDLE clears rcnt.
  - Repeat pulses drive key_pulse and the encoder exactly like press pulses.
- Undefined:
  - rcnt logic, HOLD_CYCLES and REPEAT_CYCLES are removed.
  - Exactly one pulse per accepted press, regardless of hold time.

Test Plan:
- Reset released, key_raw[3] 0->1 at t0 and held 20 cycles (macro off) -> key_pulse[3], key_valid=1 and key_code=3 for one cycle at edge t0+6; key_held[3]=1 from the same edge; no further pulses.
- key_raw[5] high for 3 cycles, then low (DEB_CYCLES=4) -> no pulse; key_held stays 0.
- key_raw[7] pressed, then a 2-cycle low bounce while held -> single pulse only; key_held[7] never drops.
- key_raw[2] and key_raw[9] rising on the same edge -> both pulse bits set on the same cycle; key_code=2, key_multi=1.
- KEYB_AUTOREPEAT_EN, key_raw[1] held 100 cycles -> pulses at P, P+50, P+60, P+70, P+80, P+90 (relative to first pulse P), then none after release.
- reset driven low during HELD with the key still pressed, released 3 cycles later -> outputs 0 during reset; one new pulse DEB_CYCLES+2 edges after reset release.
